iqdemap_qpsk_pack: RTL
======================

# iqdemap_qpsk_pack

QPSK hard-decision demapper and word packer for the one-segment receive path. It accepts one equalized complex symbol per cycle as signed 11-bit I/Q, slices each symbol to 2 bits and packs 64 symbols into a 128-bit word. Completed words go into a 2-entry show-ahead output buffer drained by a reader handshake. It is the receive-side counterpart of the QPSK IQ mapper: it sits between equalization and the bit deinterleaver/decoder.

## Interface
- THRESH, default 11'd64: low-confidence slicing threshold on |xr| and |xi|, unsigned.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- ce  in  1  clock enable for the symbol input; when low, valid_i is ignored.
- valid_i  in  1  xr/xi hold a symbol; accepted when ce && valid_i.
- sync_i  in  1  qualified by accept: this symbol is index 0 of a new word.
- xr  in  11  in-phase sample, two's complement.
- xi  in  11  quadrature sample, two's complement.
- rd_en  in  1  reader pops the head word; ignored when word_valid is low; independent of ce.
- data_o  out  128  head word of the output buffer.
- lowconf_o  out  7  number of low-confidence symbols in the head word, 0..64.
- word_valid  out  1  output buffer is non-empty.
- full  out  1  output buffer holds 2 words.
- overflow  out  1  sticky: a completed word was dropped.
- partial_drop  out  1  one-cycle pulse: a partial word was discarded by sync_i.
- valid_raw  out  1  raw carries the slice of the last accepted symbol.
- raw  out  2  {b0,b1} of the last accepted symbol.

## Operation
- Slicing: b0 = xr[10] and b1 = xi[10], so a negative value gives 1. Zero slices to 0.
- Low confidence: a symbol is low confidence if |xr| < THRESH or |xi| < THRESH. The absolute value is computed at 12 bits, so -1024 gives 1024 with no wrap.
- Packing: a 6-bit symbol index k runs 0..63. b0 goes to bit 127-2k and b1 to bit 126-2k, so symbol 0 occupies the MSBs. A per-word low-confidence counter (7 bits) accumulates alongside.
- When the symbol with k = 63 is accepted, the complete word and its count are pushed to the buffer. k then wraps to 0 and the count clears.
- Sync: an accepted symbol with sync_i = 1 is stored as k = 0 of a fresh word.
  - If k was nonzero, the partial word and its count are discarded and partial_drop pulses.
  - If k was already 0, sync_i has no side effect.
- Buffer: 2-entry FIFO, show-ahead. data_o and lowconf_o show the head entry whenever word_valid = 1.
  - Push and pop in the same cycle is always legal, including when full. The pop frees the slot.
  - Push while full with no pop: the new word is dropped and overflow is set. overflow clears only on reset.
  - Pop while empty has no effect.
- Reset, asynchronous, mid-operation: the partial word, index, count and buffer are cleared. All outputs go to 0: data_o, lowconf_o, word_valid, full, overflow, partial_drop, valid_raw, raw.

## Timing
- A symbol accepted at cycle t appears on raw/valid_raw at t+1. valid_raw is low at t+1 if nothing was accepted at t. raw holds its last value when valid_raw is low.
- When symbol k = 63 is accepted at t, the word is in the buffer at t+1: word_valid = 1 and data_o is valid at t+1 if the buffer was empty.
- A pop at cycle t (rd_en && word_valid) updates data_o, word_valid and full at t+1.
- partial_drop is asserted at t+1 for a sync that discards a partial word at t.
- full = (occupancy == 2) and word_valid = (occupancy != 0), both registered from occupancy.
- Throughput: 1 symbol/cycle sustained. One word per 64 accepted symbols. Input-side backpressure does not exist; the reader must keep up or words are lost.

## Test plan
- Reset, then 64 accepted symbols alternating (xr,xi) = (+100,+100) and (-100,-100) -> at t+1 after the last symbol, word_valid = 1, data_o = 128'h3333...3333, lowconf_o = 0.
- 64 symbols (xr,xi) = (-1024,+5) with THRESH = 64 -> data_o = 128'hAAAA...AAAA, lowconf_o = 64; raw = 2'b10 with valid_raw one cycle after each accept.
- Push 3 words with rd_en = 0 -> full = 1 after the 2nd word. The 3rd word is dropped and overflow = 1. Popping returns words 1 and 2 in order.
- With full = 1, complete a word and assert rd_en in the same cycle -> no overflow. The buffer still holds 2 words, now words 2 and 3.
- Accept 10 symbols, then a symbol with sync_i = 1 -> partial_drop pulses once. The next word contains the sync symbol at bits 127:126.
- Toggle ce low mid-word while valid_i = 1 -> those symbols are ignored; k and raw are unchanged. Assert RST low mid-word -> all outputs are 0 immediately, and the next word packs from k = 0.

Source files
------------

// File: rtl/iqdemap_qpsk_pack.sv
// QPSK hard-decision demapper: slices signed I/Q to 2 bits, packs 64 symbols per
// 128-bit word with a low-confidence count, and queues words in a 2-entry show-ahead buffer.
module iqdemap_qpsk_pack #(
  parameter logic [10:0] THRESH = 11'd64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ce,
  input  logic         valid_i,
  input  logic         sync_i,
  input  logic [10:0]  xr,
  input  logic [10:0]  xi,
  input  logic         rd_en,
  output logic [127:0] data_o,
  output logic [6:0]   lowconf_o,
  output logic         word_valid,
  output logic         full,
  output logic         overflow,
  output logic         partial_drop,
  output logic         valid_raw,
  output logic [1:0]   raw
);

  // Magnitude at 12 bits so that -1024 maps to +1024 instead of wrapping.
  function automatic logic [11:0] abs12(input logic [10:0] v);
    logic [11:0] ext;
    ext = {v[10], v};
    if (v[10]) begin
      abs12 = 12'd0 - ext;
    end else begin
      abs12 = ext;
    end
  endfunction

  logic         accept;
  logic [11:0]  abs_r;
  logic [11:0]  abs_i;
  logic         lowconf;

  logic [127:0] word;
  logic [5:0]   k;
  logic [6:0]   cnt;

  logic [5:0]   idx;
  logic [6:0]   base_cnt;
  logic [127:0] word_next;
  logic [6:0]   cnt_next;
  logic [6:0]   cnt_keep;
  logic [5:0]   k_next;
  logic         push;
  logic         discard;

  logic [127:0] slot1_d;
  logic [6:0]   slot1_c;
  logic [1:0]   occ;
  logic         pop;

  logic [127:0] n_d0;
  logic [6:0]   n_c0;
  logic [127:0] n_d1;
  logic [6:0]   n_c1;
  logic [1:0]   n_occ;
  logic         set_ovf;

  assign accept  = ce & valid_i;
  assign abs_r   = abs12(xr);
  assign abs_i   = abs12(xi);
  assign lowconf = (abs_r < {1'b0, THRESH}) | (abs_i < {1'b0, THRESH});
  assign pop     = rd_en & word_valid;

  // Symbol placement, per-word count and word completion for the accepted symbol.
  always_comb begin
    idx       = k;
    base_cnt  = cnt;
    word_next = word;
    cnt_next  = cnt;
    cnt_keep  = cnt;
    k_next    = k;
    push      = 1'b0;
    discard   = 1'b0;
    if (accept) begin
      if (sync_i) begin
        idx      = 6'd0;
        base_cnt = 7'd0;
        discard  = (k != 6'd0);
      end else begin
        idx      = k;
        base_cnt = cnt;
      end
      // Symbol 0 lands in the MSBs; stale bits of a dropped partial word are
      // all overwritten before the next completed word is pushed.
      word_next[7'd127 - {idx, 1'b0}] = xr[10];
      word_next[7'd126 - {idx, 1'b0}] = xi[10];
      cnt_next = base_cnt + {6'd0, lowconf};
      if (idx == 6'd63) begin
        push     = 1'b1;
        k_next   = 6'd0;
        cnt_keep = 7'd0;
      end else begin
        k_next   = idx + 6'd1;
        cnt_keep = cnt_next;
      end
    end else begin
      k_next   = k;
      cnt_keep = cnt;
    end
  end

  // Output buffer next state; slot 0 is the head and drives data_o directly.
  always_comb begin
    n_d0    = data_o;
    n_c0    = lowconf_o;
    n_d1    = slot1_d;
    n_c1    = slot1_c;
    n_occ   = occ;
    set_ovf = 1'b0;
    case (occ)
      2'd0: begin
        if (push) begin
          n_d0  = word_next;
          n_c0  = cnt_next;
          n_occ = 2'd1;
        end else begin
          n_occ = 2'd0;
        end
      end
      2'd1: begin
        if (push && pop) begin
          n_d0  = word_next;
          n_c0  = cnt_next;
          n_occ = 2'd1;
        end else if (push) begin
          n_d1  = word_next;
          n_c1  = cnt_next;
          n_occ = 2'd2;
        end else if (pop) begin
          n_occ = 2'd0;
        end else begin
          n_occ = 2'd1;
        end
      end
      2'd2: begin
        if (push && pop) begin
          n_d0  = slot1_d;
          n_c0  = slot1_c;
          n_d1  = word_next;
          n_c1  = cnt_next;
          n_occ = 2'd2;
        end else if (pop) begin
          n_d0  = slot1_d;
          n_c0  = slot1_c;
          n_occ = 2'd1;
        end else if (push) begin
          set_ovf = 1'b1;
          n_occ   = 2'd2;
        end else begin
          n_occ = 2'd2;
        end
      end
      default: begin
        n_occ = 2'd0;
      end
    endcase
  end

  // Packing state and raw slice outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      word         <= 128'd0;
      k            <= 6'd0;
      cnt          <= 7'd0;
      partial_drop <= 1'b0;
      valid_raw    <= 1'b0;
      raw          <= 2'b00;
    end else begin
      word         <= word_next;
      k            <= k_next;
      cnt          <= cnt_keep;
      partial_drop <= discard;
      valid_raw    <= accept;
      if (accept) begin
        raw <= {xr[10], xi[10]};
      end else begin
        raw <= raw;
      end
    end
  end

  // Output buffer registers and status flags derived from the next occupancy.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_o     <= 128'd0;
      lowconf_o  <= 7'd0;
      slot1_d    <= 128'd0;
      slot1_c    <= 7'd0;
      occ        <= 2'd0;
      word_valid <= 1'b0;
      full       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      data_o     <= n_d0;
      lowconf_o  <= n_c0;
      slot1_d    <= n_d1;
      slot1_c    <= n_c1;
      occ        <= n_occ;
      word_valid <= (n_occ != 2'd0);
      full       <= (n_occ == 2'd2);
      overflow   <= overflow | set_ovf;
    end
  end

endmodule
